// File: rtl/uart_program_yukleyici_pkg.sv
// Shared types and defaults for the UART program loader.
// Optional checksum stage: UART_YUKLEYICI_SAGLAMA_EN.
package uart_program_yukleyici_pkg;

   typedef enum logic [2:0] {
      BOSTA   = 3'd0,
      SAY_L   = 3'd1,
      SAY_H   = 3'd2,
      VERI    = 3'd3,
      YAZ     = 3'd4,
      SAGLAMA = 3'd5,
      BITTI   = 3'd6
   } durum_t;

   localparam logic [7:0] SIHIRLI_VARSAYILAN     = 8'hA5;
   localparam int         ZAMAN_ASIMI_VARSAYILAN = 1000000;
   localparam int         SAYI_W                 = 16;

endpackage

// File: rtl/uart_kelime_paketleyici.sv
// Packs four received bytes into a little-endian 32-bit word; first byte ends in [7:0].
module uart_kelime_paketleyici
   import uart_program_yukleyici_pkg::*;
(
   input  logic        clk_g,
   input  logic        rst_g,
   input  logic        temizle,
   input  logic        gecerli,
   input  logic [7:0]  veri,
   output logic [31:0] kelime,
   output logic        bitti
);

   logic [1:0] sayac;

   always_ff @(posedge clk_g or negedge rst_g) begin
      if (!rst_g) begin
         sayac  <= 2'd0;
         kelime <= 32'd0;
      end else if (temizle) begin
         sayac <= 2'd0;
      end else if (gecerli) begin
         kelime <= {veri, kelime[31:8]};
         sayac  <= sayac + 2'd1;
      end
   end

   assign bitti = gecerli && (sayac == 2'd3);

endmodule

// File: rtl/uart_program_yukleyici.sv
// Loads a framed program image from the UART byte stream into instruction memory.
// Optional checksum stage: UART_YUKLEYICI_SAGLAMA_EN.
//
// state   | meaning
// BOSTA   | idle, waiting for the start byte
// SAY_L   | expecting count low byte
// SAY_H   | expecting count high byte
// VERI    | collecting data bytes into a word
// YAZ     | word write pending on the memory handshake
// SAGLAMA | expecting the XOR checksum byte
// BITTI   | image loaded, core released
module uart_program_yukleyici
   import uart_program_yukleyici_pkg::*;
#(
   parameter int         ADRES_W     = 10,
   parameter logic [7:0] SIHIRLI     = SIHIRLI_VARSAYILAN,
   parameter int         ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
   input  logic               clk_g,
   input  logic               rst_g,
   input  logic [7:0]         al_veri,
   input  logic               al_gecerli,
   output logic               yaz_gecerli,
   input  logic               yaz_hazir,
   output logic [ADRES_W-1:0] yaz_adres,
   output logic [31:0]        yaz_veri,
   output logic               cekirdek_rst,
   output logic               yukleme_bitti,
   output logic               hata
);

   localparam int             TW       = $clog2(ZAMAN_ASIMI + 1);
   localparam logic [TW-1:0]  YENIDEN  = TW'(ZAMAN_ASIMI - 1);
   localparam logic [16:0]    DERINLIK = 17'd1 << ADRES_W;
`ifdef UART_YUKLEYICI_SAGLAMA_EN
   localparam durum_t         SON_DURUM = SAGLAMA;
`else
   localparam durum_t         SON_DURUM = BITTI;
`endif

   durum_t              durum, durum_n;
   logic [SAYI_W-1:0]   sayi;
   logic [SAYI_W-1:0]   yeni_sayi;
   logic [ADRES_W:0]    indeks;
   logic [TW-1:0]       zamanlayici;
   logic                aktif, zaman_doldu, hata_set, son_kelime, sihirli_geldi;
   logic [31:0]         kelime;
   logic                pk_bitti;
`ifdef UART_YUKLEYICI_SAGLAMA_EN
   logic [7:0]          saglama;
`endif

   assign aktif         = (durum != BOSTA) && (durum != BITTI);
   assign zaman_doldu   = aktif && !al_gecerli && (zamanlayici == '0);
   assign yeni_sayi     = {al_veri, sayi[7:0]};
   assign son_kelime    = ((17'(indeks) + 17'd1) == {1'b0, sayi});
   assign sihirli_geldi = (durum == BOSTA) && al_gecerli && (al_veri == SIHIRLI);

   uart_kelime_paketleyici u_paketleyici (
      .clk_g   (clk_g),
      .rst_g   (rst_g),
      .temizle (durum == BOSTA),
      .gecerli (al_gecerli && (durum == VERI)),
      .veri    (al_veri),
      .kelime  (kelime),
      .bitti   (pk_bitti)
   );

   always_ff @(posedge clk_g or negedge rst_g) begin
      if (!rst_g) durum <= BOSTA;
      else        durum <= durum_n;
   end

   always_comb begin
      durum_n  = durum;
      hata_set = 1'b0;
      case (durum)
         BOSTA:   if (sihirli_geldi) durum_n = SAY_L;
         SAY_L:   if (al_gecerli) durum_n = SAY_H;
         SAY_H: begin
            if (al_gecerli) begin
               if (yeni_sayi == '0) begin
                  durum_n = SON_DURUM;
               end else if ({1'b0, yeni_sayi} > DERINLIK) begin
                  hata_set = 1'b1;
                  durum_n  = BOSTA;
               end else begin
                  durum_n = VERI;
               end
            end
         end
         VERI:    if (pk_bitti) durum_n = YAZ;
         YAZ: begin
            // A byte arriving while the write is still pending is an overrun.
            if (al_gecerli) begin
               hata_set = 1'b1;
               durum_n  = BOSTA;
            end else if (yaz_hazir) begin
               durum_n = son_kelime ? SON_DURUM : VERI;
            end
         end
`ifdef UART_YUKLEYICI_SAGLAMA_EN
         SAGLAMA: begin
            if (al_gecerli) begin
               if (al_veri == saglama) begin
                  durum_n = BITTI;
               end else begin
                  hata_set = 1'b1;
                  durum_n  = BOSTA;
               end
            end
         end
`endif
         BITTI:   durum_n = BITTI;
         default: durum_n = BOSTA;
      endcase
      if (zaman_doldu) begin
         hata_set = 1'b1;
         durum_n  = BOSTA;
      end
   end

   always_comb begin
      yaz_gecerli   = (durum == YAZ);
      cekirdek_rst  = (durum != BITTI);
      yukleme_bitti = (durum == BITTI);
      yaz_adres     = indeks[ADRES_W-1:0];
      yaz_veri      = kelime;
   end

   always_ff @(posedge clk_g or negedge rst_g) begin
      if (!rst_g) begin
         sayi        <= '0;
         indeks      <= '0;
         hata        <= 1'b0;
         zamanlayici <= '0;
`ifdef UART_YUKLEYICI_SAGLAMA_EN
         saglama     <= 8'd0;
`endif
      end else begin
         if (sihirli_geldi)  hata <= 1'b0;
         else if (hata_set)  hata <= 1'b1;
         if (durum == SAY_L && al_gecerli) sayi[7:0] <= al_veri;
         if (durum == SAY_H && al_gecerli) begin
            sayi[15:8] <= al_veri;
            indeks     <= '0;
         end
         if (durum == YAZ && yaz_hazir && !al_gecerli && !zaman_doldu)
            indeks <= indeks + 1'b1;
`ifdef UART_YUKLEYICI_SAGLAMA_EN
         if (sihirli_geldi)                  saglama <= 8'd0;
         else if (durum == VERI && al_gecerli) saglama <= saglama ^ al_veri;
`endif
         // Down-counter: reloaded on every byte and whenever idle or finished.
         if (al_gecerli || !aktif)     zamanlayici <= YENIDEN;
         else if (zamanlayici != '0)   zamanlayici <= zamanlayici - 1'b1;
      end
   end

endmodule
